soc_system_lcd_timing: RTL and testbench

SOC_SYSTEM_LCD_TIMING -- requirements
Module: soc_system_lcd_timing

---
 rtl/lcd_timing_pkg.sv | 34 +++
 rtl/lcd_dclk_div.sv | 68 ++++++
 rtl/soc_system_lcd_timing.sv | 145 ++++++++++++++
 tb/tb_soc_system_lcd_timing.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg
//   Shared constants for the LCD timing generator: default panel timing,
//   the layout of the control word coming from the LCD_CLK PIO, and the
//   width of the pixel/line counters. Small helpers split the control word.
package lcd_timing_pkg;

    // Counter width for h, v, pix_x and pix_y
    localparam int CNT_W = 11;

    // Control word layout: bit0 = enable, bits[7:1] = divider DIV
    localparam int CTRL_W       = 8;
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIV_LSB = 1;
    localparam int DIV_W        = 7;

    // Default 800x480 panel timing
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 48;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 13;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 32;

    function automatic logic ctrl_en(input logic [CTRL_W-1:0] c);
        return c[CTRL_EN_BIT];
    endfunction

    function automatic logic [DIV_W-1:0] ctrl_div(input logic [CTRL_W-1:0] c);
        return c[CTRL_DIV_LSB +: DIV_W];
    endfunction

endpackage

// File: rtl/lcd_dclk_div.sv
// lcd_dclk_div
//   Prescaler producing the panel pixel clock and the pixel-request strobe.
//   pcnt counts 0..DIV; each wrap toggles dclk, so the dclk period is
//   2*(DIV+1) clk. DIV is re-latched only at a wrap or while disabled.
//   After enable rises, one start clk is spent before counting so that the
//   first dclk rise lands DIV+1 clk after the first pixel is presented.
// Ports
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   i_en      : enable from the control word
//   i_div     : divider DIV from the control word
//   o_dclk    : registered pixel clock
//   o_pix_en  : registered one-clk strobe, high after each dclk 1->0 edge
//   o_adv     : combinational, high on the clk edge where dclk falls
module lcd_dclk_div
    import lcd_timing_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_dclk,
    output logic             o_pix_en,
    output logic             o_adv
);

    logic [DIV_W-1:0] r_pcnt;
    logic [DIV_W-1:0] r_div;
    logic             r_run;
    logic             r_dclk;
    logic             r_pix_en;
    logic             w_wrap;

    assign w_wrap   = r_run && (r_pcnt == r_div);
    // The falling dclk edge is the one where pixel counters advance
    assign o_adv    = i_en && w_wrap && r_dclk;
    assign o_dclk   = r_dclk;
    assign o_pix_en = r_pix_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt   <= '0;
            r_div    <= '0;
            r_run    <= 1'b0;
            r_dclk   <= 1'b0;
            r_pix_en <= 1'b0;
        end else if (!i_en) begin
            r_pcnt   <= '0;
            r_div    <= i_div;
            r_run    <= 1'b0;
            r_dclk   <= 1'b0;
            r_pix_en <= 1'b0;
        end else if (!r_run) begin
            // start clk: pixel (0,0) is being presented, counting begins next clk
            r_run    <= 1'b1;
            r_pix_en <= 1'b0;
        end else if (w_wrap) begin
            r_pcnt   <= '0;
            r_dclk   <= ~r_dclk;
            r_pix_en <= r_dclk;
            r_div    <= i_div;
        end else begin
            r_pcnt   <= r_pcnt + DIV_W'(1);
            r_pix_en <= 1'b0;
        end
    end

endmodule

// File: rtl/soc_system_lcd_timing.sv
// soc_system_lcd_timing
//   LCD panel timing generator. Produces dclk, a pixel request strobe,
//   hsync/vsync/de and the active pixel coordinate from a control word
//   (bit0 enable, bits[7:1] clock divider).
//   Optional feature: define LCD_TIMING_FRAME_IRQ_EN to add frame_irq, a
//   one-clk pulse on the pixel strobe where the line counter wraps to 0.
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset, overrides enable
//   ctrl[7:0]  : control word {DIV[6:0], enable}
//   lcd_dclk   : pixel clock to the panel
//   pix_en     : one-clk strobe requesting the next pixel
//   lcd_hsync  : horizontal sync, active high
//   lcd_vsync  : vertical sync, active high
//   lcd_de     : data enable, active high
//   pix_x/y    : active pixel coordinate, 0 outside the active area
//   frame_irq  : (LCD_TIMING_FRAME_IRQ_EN only) end-of-frame pulse
module soc_system_lcd_timing
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrl,
    output logic              lcd_dclk,
    output logic              pix_en,
    output logic              lcd_hsync,
    output logic              lcd_vsync,
    output logic              lcd_de,
    output logic [CNT_W-1:0]  pix_x,
    output logic [CNT_W-1:0]  pix_y
`ifdef LCD_TIMING_FRAME_IRQ_EN
    ,
    output logic              frame_irq
`endif
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYB  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYE  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYB  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYE  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             w_en;
    logic [DIV_W-1:0] w_div;
    logic             w_adv;
    logic             w_h_last;
    logic             w_v_last;
    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;
    logic             w_de_nxt;

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_de;
    logic             r_hsync;
    logic             r_vsync;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;

    assign w_en  = ctrl_en(ctrl);
    assign w_div = ctrl_div(ctrl);

    lcd_dclk_div u_div (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_en),
        .i_div    (w_div),
        .o_dclk   (lcd_dclk),
        .o_pix_en (pix_en),
        .o_adv    (w_adv)
    );

    // Decode is taken from the next counter value so that sync/de/coordinate
    // change on the same clk as pix_en, a full half dclk before the rise.
    always_comb begin
        w_h_last = (r_h == H_LAST);
        w_v_last = (r_v == V_LAST);
        w_h_nxt  = r_h;
        w_v_nxt  = r_v;
        if (!w_en) begin
            w_h_nxt = '0;
            w_v_nxt = '0;
        end else if (w_adv) begin
            w_h_nxt = w_h_last ? '0 : r_h + CNT_W'(1);
            if (w_h_last) begin
                w_v_nxt = w_v_last ? '0 : r_v + CNT_W'(1);
            end
        end
        w_de_nxt = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h     <= '0;
            r_v     <= '0;
            r_de    <= 1'b0;
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
            r_de    <= w_en && w_de_nxt;
            r_hsync <= w_en && (w_h_nxt >= H_SYB) && (w_h_nxt < H_SYE);
            r_vsync <= w_en && (w_v_nxt >= V_SYB) && (w_v_nxt < V_SYE);
            r_x     <= (w_en && w_de_nxt) ? w_h_nxt : '0;
            r_y     <= (w_en && w_de_nxt) ? w_v_nxt : '0;
        end
    end

    assign lcd_de    = r_de;
    assign lcd_hsync = r_hsync;
    assign lcd_vsync = r_vsync;
    assign pix_x     = r_x;
    assign pix_y     = r_y;

`ifdef LCD_TIMING_FRAME_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_adv && w_h_last && w_v_last;
        end
    end

    assign frame_irq = r_irq;
`endif

endmodule

// File: tb/tb_soc_system_lcd_timing.sv
module tb_soc_system_lcd_timing;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ctrl;
    logic        lcd_dclk, pix_en, lcd_hsync, lcd_vsync, lcd_de;
    logic [10:0] pix_x, pix_y;
`ifdef LCD_TIMING_FRAME_IRQ_EN
    logic        frame_irq;
`endif

    always #5 clk = ~clk;

    soc_system_lcd_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_dut (
        .clk       (clk),
        .reset     (rst),
        .ctrl      (ctrl),
        .lcd_dclk  (lcd_dclk),
        .pix_en    (pix_en),
        .lcd_hsync (lcd_hsync),
        .lcd_vsync (lcd_vsync),
        .lcd_de    (lcd_de),
        .pix_x     (pix_x),
        .pix_y     (pix_y)
`ifdef LCD_TIMING_FRAME_IRQ_EN
        ,
        .frame_irq (frame_irq)
`endif
    );

    int total = 0;
    int bad   = 0;
    int nprint = 0;

    // Reference model state: time since the run started and the dividers
    bit          mchk;
    bit          m_run;
    int          m_k, m_d0, m_d, m_lat;
    logic [26:0] e_vec;
    logic        e_irq;

    function automatic logic [26:0] dutvec();
        return {lcd_dclk, pix_en, lcd_hsync, lcd_vsync, lcd_de, pix_x, pix_y};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            if (nprint < 30) begin
                nprint++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
        end
    endtask

    // The first dclk toggle comes d0+1 clk after the start clk (d0 = divider
    // latched before the run), then one toggle every d+1 clk. Every second
    // toggle is a falling edge that moves on to the next pixel.
    task automatic model_tick();
        int t1, c, n, h, v;
        bit tog, dk, pen, de, hs, vs;
        if (rst) begin
            m_run = 0; m_lat = 0;
        end else if (!ctrl[0]) begin
            m_run = 0; m_lat = int'(ctrl[7:1]);
        end else if (!m_run) begin
            m_run = 1; m_k = 0; m_d0 = m_lat; m_d = int'(ctrl[7:1]);
        end else begin
            m_k++;
        end
        if (!m_run) begin
            e_vec = '0;
            e_irq = 1'b0;
        end else begin
            t1 = m_d0 + 1;
            if (m_k < t1) begin
                c = 0; tog = 0;
            end else begin
                c = 1 + (m_k - t1) / (m_d + 1);
                tog = ((m_k - t1) % (m_d + 1)) == 0;
            end
            dk  = (c % 2) == 1;
            pen = tog && ((c % 2) == 0);
            n   = c / 2;
            h   = n % HT;
            v   = (n / HT) % VT;
            de  = (h < HA) && (v < VA);
            hs  = (h >= HA + HF) && (h < HA + HF + HS);
            vs  = (v >= VA + VF) && (v < VA + VF + VS);
            e_vec = {dk, pen, hs, vs, de, de ? 11'(h) : 11'd0, de ? 11'(v) : 11'd0};
            e_irq = pen && ((n % (HT * VT)) == 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_tick();
        if (mchk) begin
            chk("cycle_outputs", dutvec(), e_vec);
`ifdef LCD_TIMING_FRAME_IRQ_EN
            chk("cycle_frame_irq", frame_irq, e_irq);
`endif
        end
    endtask

    initial begin
        int   cnt_pen, cnt_vs, last_rise, gmin, gmax;
        int   hmin, hmax, lmin, lmax, runlen, rises;
        int   tq[$];
        int   rq[$];
        int   len, rpos;
        bit   found;
        logic prev;
        logic [6:0] d;

        rst = 1'b1; ctrl = 8'h00; mchk = 1;
        m_run = 0; m_k = 0; m_d0 = 0; m_d = 0; m_lat = 0;
        step();
        step();
        chk("reset_outputs", dutvec(), 27'd0);
        rst = 1'b0;
        step();

        // DIV=0: dclk = clk/2, 40 pixels per frame, vsync over 8 pixels
        ctrl = 8'h01;
        step();
        chk("start_de", lcd_de, 1'b1);
        chk("start_xy", {pix_x, pix_y}, 22'd0);
        cnt_pen = 0; cnt_vs = 0; last_rise = -1; gmin = 999; gmax = 0;
        for (int i = 1; i <= 80; i++) begin
            prev = lcd_dclk;
            step();
            if (pix_en) begin
                cnt_pen++;
                if (lcd_vsync) cnt_vs++;
            end
            if (lcd_dclk && !prev) begin
                if (last_rise >= 0) begin
                    if (i - last_rise < gmin) gmin = i - last_rise;
                    if (i - last_rise > gmax) gmax = i - last_rise;
                end
                last_rise = i;
            end
        end
        chk("div0_pix_en_per_frame", cnt_pen, 40);
        chk("div0_vsync_pixels", cnt_vs, 8);
        chk("div0_period_min", gmin, 2);
        chk("div0_period_max", gmax, 2);

        // DIV=3: dclk 4 high / 4 low, de and hsync pattern sampled at dclk rise
        ctrl = 8'h06;
        step();
        ctrl = 8'h07;
        step();
        hmin = 999; hmax = 0; lmin = 999; lmax = 0; runlen = 1; rises = 0;
        for (int i = 1; i <= 130; i++) begin
            prev = lcd_dclk;
            step();
            if (lcd_dclk != prev) begin
                if (prev) begin
                    if (runlen < hmin) hmin = runlen;
                    if (runlen > hmax) hmax = runlen;
                end else begin
                    if (runlen < lmin) lmin = runlen;
                    if (runlen > lmax) lmax = runlen;
                end
                runlen = 1;
            end else begin
                runlen++;
            end
            if (lcd_dclk && !prev && rises < 16) begin
                chk("div3_de_at_rise", lcd_de, (rises % 8) < 4);
                chk("div3_hsync_at_rise", lcd_hsync, ((rises % 8) == 5) || ((rises % 8) == 6));
                rises++;
            end
        end
        chk("div3_rises", rises, 16);
        chk("div3_high_min", hmin, 4);
        chk("div3_high_max", hmax, 4);
        chk("div3_low_min", lmin, 4);
        chk("div3_low_max", lmax, 4);

        // Divider change mid-run: current half-period completes, then 6-clk period
        ctrl = 8'h00;
        step();
        ctrl = 8'h01;
        step();
        repeat (5) step();
        mchk = 0;
        ctrl = 8'h05;
        for (int i = 1; i <= 20; i++) begin
            prev = lcd_dclk;
            step();
            if (lcd_dclk != prev) tq.push_back(i);
            if (lcd_dclk && !prev) rq.push_back(i);
        end
        chk("chg_toggle_count", tq.size() >= 4 && rq.size() >= 3, 1'b1);
        if (tq.size() >= 4 && rq.size() >= 3) begin
            chk("chg_old_half", tq[0], 1);
            chk("chg_new_half", tq[2] - tq[1], 3);
            chk("chg_new_period", rq[2] - rq[1], 6);
        end
        ctrl = 8'h00;
        mchk = 1;
        step();

        // Enable dropped at (2,1), then re-enabled
        ctrl = 8'h01;
        step();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (lcd_de && pix_x == 11'd2 && pix_y == 11'd1) found = 1;
        end
        chk("dis_reach_2_1", found, 1'b1);
        ctrl = 8'h00;
        step();
        chk("dis_outputs", dutvec(), 27'd0);
        ctrl = 8'h01;
        step();
        chk("reen_x", pix_x, 11'd0);
        chk("reen_y", pix_y, 11'd0);
        chk("reen_de", lcd_de, 1'b1);

        // Reset mid-line with enable high
        ctrl = 8'h02;
        step();
        ctrl = 8'h03;
        step();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (lcd_de && pix_x == 11'd1) found = 1;
        end
        chk("rst_reach_midline", found, 1'b1);
        rst = 1'b1;
        step();
        chk("rst_outputs", dutvec(), 27'd0);
        rst = 1'b0;
        step();
        chk("rst_release_de", lcd_de, 1'b1);
        chk("rst_release_xy", {pix_x, pix_y}, 22'd0);
        repeat (60) step();

`ifdef LCD_TIMING_FRAME_IRQ_EN
        ctrl = 8'h00;
        step();
        ctrl = 8'h01;
        step();
        cnt_pen = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (frame_irq) cnt_pen++;
        end
        chk("irq_per_200clk", cnt_pen, 2);
`endif

        // Randomized runs: divider changed while disabled, occasional reset
        for (int s = 0; s < 25; s++) begin
            d = 7'($urandom_range(0, 3));
            ctrl = {d, 1'b0};
            repeat ($urandom_range(1, 3)) step();
            ctrl[0] = 1'b1;
            len  = $urandom_range(30, 300);
            rpos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, len - 5)) : -10;
            for (int i = 0; i < len; i++) begin
                rst = (i == rpos) || (i == rpos + 1);
                step();
            end
            rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
